// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-channel TDM demultiplexer with frame lock and sync-error detection
module tdm_demux4 #(
    parameter int WIDTH       = 8,
    parameter bit STRICT_SYNC = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0_out,
    output logic [WIDTH-1:0] ch1_out,
    output logic [WIDTH-1:0] ch2_out,
    output logic [WIDTH-1:0] ch3_out,
    output logic [3:0]       ch_valid,
    output logic             frame_done,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              slot_q, slot_d;
    logic [3:0][WIDTH-1:0]   ch_q, ch_d;
    logic [3:0]              ch_valid_q, ch_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    sync_err_q, sync_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= 2'd0;
            ch_q         <= '0;
            ch_valid_q   <= 4'd0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            ch_q         <= ch_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        ch_d         = ch_q;
        ch_valid_d   = 4'd0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        ch_d[0]    = din;
                        ch_valid_d = 4'b0001;
                        slot_d     = 2'd1;
                        state_d    = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // Sync mid-frame abandons the partial frame and restarts at slot 0.
                        sync_err_d = (slot_q != 2'd0);
                        ch_d[0]    = din;
                        ch_valid_d = 4'b0001;
                        slot_d     = 2'd1;
                    end else if (slot_q == 2'd0 && STRICT_SYNC) begin
                        sync_err_d = 1'b1;
                        slot_d     = 2'd0;
                        state_d    = HUNT;
                    end else begin
                        ch_d[slot_q] = din;
                        ch_valid_d   = 4'b0001 << slot_q;
                        frame_done_d = (slot_q == 2'd3);
                        slot_d       = slot_q + 2'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    assign ch0_out    = ch_q[0];
    assign ch1_out    = ch_q[1];
    assign ch2_out    = ch_q[2];
    assign ch3_out    = ch_q[3];
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - randomized and directed bench for tdm_demux4, strict and flywheel builds
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] din = 8'd0;

    logic [7:0] u_ch [2][4];
    logic [3:0] u_cv [2];
    logic       u_fd [2];
    logic       u_lk [2];
    logic       u_se [2];

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    // Reference: index 0 is the strict build, index 1 the flywheel build.
    int         m_lock [2];
    int         m_slot [2];
    logic [7:0] m_ch [2][4];
    logic [3:0] m_cv [2];
    logic       m_fd [2];
    logic       m_se [2];

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(8), .STRICT_SYNC(1'b1)) u_strict (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .ch0_out(u_ch[0][0]), .ch1_out(u_ch[0][1]), .ch2_out(u_ch[0][2]), .ch3_out(u_ch[0][3]),
        .ch_valid(u_cv[0]), .frame_done(u_fd[0]), .locked(u_lk[0]), .sync_err(u_se[0])
    );

    tdm_demux4 #(.WIDTH(8), .STRICT_SYNC(1'b0)) u_fly (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .ch0_out(u_ch[1][0]), .ch1_out(u_ch[1][1]), .ch2_out(u_ch[1][2]), .ch3_out(u_ch[1][3]),
        .ch_valid(u_cv[1]), .frame_done(u_fd[1]), .locked(u_lk[1]), .sync_err(u_se[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = 0;
            m_slot[k] = 0;
            m_cv[k]   = 4'd0;
            m_fd[k]   = 1'b0;
            m_se[k]   = 1'b0;
            for (int s = 0; s < 4; s++) m_ch[k][s] = 8'd0;
        end
    endtask

    task automatic m_write(input int k, input int s, input logic [7:0] d);
        m_ch[k][s] = d;
        m_cv[k]    = 4'(1 << s);
        m_fd[k]    = (s == 3);
        m_slot[k]  = (s + 1) % 4;
    endtask

    task automatic m_step(input logic v, input logic fs, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            m_cv[k] = 4'd0;
            m_fd[k] = 1'b0;
            m_se[k] = 1'b0;
            if (v) begin
                if (m_lock[k] == 0) begin
                    if (fs) begin
                        m_lock[k] = 1;
                        m_write(k, 0, d);
                    end
                end else if (fs) begin
                    m_se[k] = (m_slot[k] != 0);
                    m_write(k, 0, d);
                end else if (m_slot[k] == 0 && k == 0) begin
                    m_se[k]   = 1'b1;
                    m_lock[k] = 0;
                    m_slot[k] = 0;
                end else begin
                    m_write(k, m_slot[k], d);
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic fs, input logic [7:0] d);
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        if (rst_n) m_step(v, fs, d);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ch0_u%0d", k), 32'(u_ch[k][0]), 32'h0);
            chk($sformatf("rst_ch3_u%0d", k), 32'(u_ch[k][3]), 32'h0);
            chk($sformatf("rst_lock_u%0d", k), 32'(u_lk[k]), 32'h0);
            chk($sformatf("rst_cv_u%0d", k), 32'(u_cv[k]), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                for (int s = 0; s < 4; s++)
                    chk($sformatf("u%0d_ch%0d", k, s), 32'(u_ch[k][s]), 32'(m_ch[k][s]));
                chk($sformatf("u%0d_ch_valid", k), 32'(u_cv[k]), 32'(m_cv[k]));
                chk($sformatf("u%0d_frame_done", k), 32'(u_fd[k]), 32'(m_fd[k]));
                chk($sformatf("u%0d_sync_err", k), 32'(u_se[k]), 32'(m_se[k]));
                chk($sformatf("u%0d_locked", k), 32'(u_lk[k]), 32'(m_lock[k] != 0));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_cnt [2];
        int cnt;
        logic v, fs;

        m_reset();
        @(posedge clk);
        #1;
        checking = 1'b1;
        chk("reset_locked", 32'(u_lk[0]), 32'h0);
        chk("reset_ch0", 32'(u_ch[0][0]), 32'h0);
        rst_n = 1'b1;

        // Basic frame A1 B2 C3 D4
        step(1, 1, 8'hA1);
        chk("f1_cv0", 32'(u_cv[0]), 32'h1);
        chk("f1_locked", 32'(u_lk[0]), 32'h1);
        step(1, 0, 8'hB2);
        chk("f1_cv1", 32'(u_cv[0]), 32'h2);
        chk("f1_fd_early", 32'(u_fd[0]), 32'h0);
        step(1, 0, 8'hC3);
        chk("f1_cv2", 32'(u_cv[0]), 32'h4);
        step(1, 0, 8'hD4);
        chk("f1_cv3", 32'(u_cv[0]), 32'h8);
        chk("f1_fd", 32'(u_fd[0]), 32'h1);
        chk("f1_chs", {u_ch[0][3], u_ch[0][2], u_ch[0][1], u_ch[0][0]}, 32'hD4C3B2A1);

        // Early sync at slot 2
        step(1, 1, 8'h11);
        step(1, 0, 8'h22);
        step(1, 1, 8'h77);
        chk("es_sync_err", 32'(u_se[0]), 32'h1);
        chk("es_ch0", 32'(u_ch[0][0]), 32'h77);
        chk("es_cv", 32'(u_cv[0]), 32'h1);
        chk("es_fd", 32'(u_fd[0]), 32'h0);
        step(1, 0, 8'h88);
        chk("es_next_ch1", 32'(u_ch[0][1]), 32'h88);
        chk("es_next_cv", 32'(u_cv[0]), 32'h2);
        chk("es_err_gone", 32'(u_se[0]), 32'h0);

        // Missing sync at slot 0: strict drops lock, flywheel writes
        step(1, 0, 8'h33);
        step(1, 0, 8'h44);
        step(1, 0, 8'h99);
        chk("strict_se", 32'(u_se[0]), 32'h1);
        chk("strict_lock", 32'(u_lk[0]), 32'h0);
        chk("strict_ch0", 32'(u_ch[0][0]), 32'h77);
        chk("fly_ch0", 32'(u_ch[1][0]), 32'h99);
        chk("fly_lock", 32'(u_lk[1]), 32'h1);
        chk("fly_se", 32'(u_se[1]), 32'h0);

        // Hunt without sync
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 8'h55);
        chk("hunt_cv", 32'(u_cv[0]), 32'h0);
        chk("hunt_ch0", 32'(u_ch[0][0]), 32'h0);
        chk("hunt_lock", 32'(u_lk[0]), 32'h0);
        chk("hunt_se", 32'(u_se[0]), 32'h0);

        // Gapped stream over two frames
        do_reset();
        fd_cnt[0] = 0;
        fd_cnt[1] = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, (i % 4) == 0, 8'(8'h20 + i));
            for (int k = 0; k < 2; k++) if (u_fd[k]) fd_cnt[k]++;
            step(0, 1'($urandom), 8'($urandom));
            for (int k = 0; k < 2; k++) if (u_fd[k]) fd_cnt[k]++;
        end
        chk("gap_fd_strict", 32'(fd_cnt[0]), 32'd2);
        chk("gap_fd_fly", 32'(fd_cnt[1]), 32'd2);
        chk("gap_ch3", 32'(u_ch[0][3]), 32'h27);

        // Reset between slots 1 and 2
        step(1, 1, 8'h41);
        step(1, 0, 8'h42);
        do_reset();
        step(1, 1, 8'h12);
        chk("post_rst_ch0", 32'(u_ch[0][0]), 32'h12);
        chk("post_rst_ch1", 32'(u_ch[0][1]), 32'h0);

        // Random stream with mostly aligned sync and occasional faults
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            v  = ($urandom_range(0, 3) != 0);
            fs = ((cnt % 4) == 0) ^ ($urandom_range(0, 11) == 0);
            step(v, fs, 8'($urandom));
            if (v) cnt++;
        end

        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division demultiplexer: the receive-side counterpart of the team's 4:1 mux.
- Takes one serial sample stream carrying 4 interleaved channels (slot 0..3, slot 0 flagged by frame_sync) and steers each accepted sample into its channel's output register.
- Raises per-channel update strobes, a frame-complete pulse, and sync-error/lock status.
- Sits between a TDM link receiver and four independent channel consumers.

Parameters:
- WIDTH, 8, sample width in bits (>=1).
- STRICT_SYNC, 1, 1 = every slot-0 sample must carry frame_sync, else lock is dropped; 0 = flywheel (slot counter free-runs once locked).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  WIDTH  muxed sample stream
- din_valid  input  1  din holds a sample this cycle
- frame_sync  input  1  qualifies din as slot 0; ignored when din_valid=0
- ch0_out  output  WIDTH  last sample for channel 0 (registered)
- ch1_out  output  WIDTH  last sample for channel 1
- ch2_out  output  WIDTH  last sample for channel 2
- ch3_out  output  WIDTH  last sample for channel 3
- ch_valid  output  4  bit i pulses one cycle when chi_out updates
- frame_done  output  1  one-cycle pulse when slot 3 of a frame is written
- locked  output  1  high while the frame alignment is established
- sync_err  output  1  one-cycle pulse on an alignment violation

Behaviour:
- Reset (rst_n=0, asynchronous): all chN_out=0, ch_valid=0, frame_done=0, sync_err=0, locked=0, slot counter=0, state=HUNT. Deassertion is sampled on clk.
- Acceptance: a sample is accepted on a rising edge with din_valid=1. With din_valid=0, nothing changes and all pulses drop to 0.
- Latency: a sample accepted at edge k is visible on chN_out after edge k. The matching ch_valid bit is high for exactly the cycle following edge k. Back-to-back acceptance every cycle is supported, so there is no stall and no ready signal.
- States: HUNT, LOCKED. The 2-bit slot counter holds the next expected slot.
- HUNT:
  - din_valid & frame_sync: write ch0_out, ch_valid=0001, slot=1, go to LOCKED, locked=1 from the next cycle.
  - din_valid & !frame_sync: sample dropped, no strobe, no sync_err.
- LOCKED, din_valid & !frame_sync:
  - slot 1..3: write ch[slot]_out, pulse ch_valid[slot], slot increments.
  - slot 3: also pulse frame_done; slot wraps 3 -> 0.
  - slot 0, STRICT_SYNC=1: sample dropped, sync_err pulse, go to HUNT, locked=0, slot=0.
  - slot 0, STRICT_SYNC=0: write ch0_out as a normal slot-0 sample, slot=1.
- LOCKED, din_valid & frame_sync:
  - slot 0: normal slot-0 write, slot=1.
  - slot 1..3 (early sync): sync_err pulse; the partial frame is abandoned with no frame_done; write ch0_out, pulse ch_valid[0], slot=1; stay LOCKED (resync in place).
  - Channels already written from the abandoned frame keep their values.
- Simultaneous pulses: frame_done, ch_valid and sync_err may coexist only as listed above. frame_done and sync_err are never high in the same cycle.
- frame_sync with din_valid=0 has no effect in any state.
- Reset mid-frame: outputs clear immediately (asynchronous), state returns to HUNT, no pulses are emitted.
- Outputs are driven only from registers; no combinational path from din to any output.

Test Plan:
- Reset, then 4 accepted samples A1,B2,C3,D4 with sync on A1 -> ch0..3_out = A1,B2,C3,D4; ch_valid = 0001,0010,0100,1000 on consecutive cycles; frame_done high only with 1000; locked=1 after the first edge.
- HUNT with din_valid=1, frame_sync=0, din=55 for 3 cycles -> no ch_valid, all chN_out=00, locked=0, sync_err=0.
- Locked, frame_sync arrives at slot 2 with din=0x77 -> sync_err one cycle, ch0_out=77, ch_valid=0001, no frame_done, the next sample goes to ch1_out.
- STRICT_SYNC=1, locked, slot-0 sample 0x99 without sync -> sync_err, locked=0, ch0_out unchanged. STRICT_SYNC=0, same stimulus -> ch0_out=99, locked stays 1.
- Gapped stream (din_valid toggling 1/0) across two frames -> ch_valid only after valid cycles, the slot order is preserved, and frame_done fires exactly twice.
- rst_n pulled low between slots 1 and 2 -> all outputs 0 without waiting for a clk edge; after release, a sync-qualified 0x12 is written to ch0_out.
